// File: rtl/display_scan.sv
// ---------------------------------------------------------------------------
// display_scan
//
// Time-multiplexed driver for an N-digit seven-segment display. A prescaler
// holds each digit for REFRESH_DIV clocks. A digit index steps through the
// digits and wraps back to 0 at the end of each frame. New values are
// double-buffered, so the displayed value only changes on a frame boundary.
//
// Parameters
//   NUM_DIGITS     number of multiplexed digits (1..8)
//   REFRESH_DIV    clk_i cycles each digit is shown (>= 1)
//   COMMON_CATHODE 1: segments/dp/enables active-high, 0: all inverted
//
// Ports
//   clk_i       in   clock
//   rst_i       in   synchronous active-high reset
//   value_i     in   4*NUM_DIGITS hex nibbles; [3:0] is digit 0 (least sig.)
//   load_i      in   capture value_i; it takes effect at the next frame start
//   blank_i     in   per-digit forced blank (segments and dp off)
//   dp_i        in   per-digit decimal point
//   lzs_i       in   leading-zero suppression enable
//   display_o   out  segments, display_o[6]=a ... display_o[0]=g
//   dp_o        out  decimal point of the selected digit
//   digit_en_o  out  one-hot digit select
//   frame_o     out  one-cycle pulse when digit 0 is shown again after a wrap
//
// All outputs are registered. Each output lags the internal digit index by
// one clock.
// ---------------------------------------------------------------------------
module display_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int COMMON_CATHODE = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    load_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    lzs_i,
    output logic [0:6]              display_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   digit_en_o,
    output logic                    frame_o
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Output "off" level. With common anode, every output except frame_o is inverted.
    localparam logic POL_INV = (COMMON_CATHODE == 0);

    // -----------------------------------------------------------------------
    // Glyph table. The result is ordered abcdefg: bit 6 = a ... bit 0 = g.
    // This matches the display_o bit numbering.
    // -----------------------------------------------------------------------
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1110011;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b0011111;
            4'hC:    g = 7'b1001110;
            4'hD:    g = 7'b0111101;
            4'hE:    g = 7'b1001111;
            default: g = 7'b1000111;   // 4'hF
        endcase
        return g;
    endfunction

    // -----------------------------------------------------------------------
    // Scan timing
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             tick;       // last cycle of the current digit
    logic             wrap;       // last cycle of the frame (idx about to return to 0)
    logic             wrap_q;     // first cycle of a new frame

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values no matter how the blocks are ordered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx    <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Value double buffer. A load goes into pending and is promoted to
    // active at the next frame boundary. A load that lands on the boundary
    // goes directly to active. This keeps the frame from tearing.
    // -----------------------------------------------------------------------
    logic [VAL_W-1:0] active;
    logic [VAL_W-1:0] pending;
    logic             pending_valid;

    // NOTE: the value registers are reset on purpose. A reset must discard a
    // pending load, and it must bring the display up showing zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else if (wrap) begin
            if (load_i) begin
                active <= value_i;
            end else if (pending_valid) begin
                active <= pending;
            end
            pending_valid <= 1'b0;
        end else if (load_i) begin
            pending       <= value_i;
            pending_valid <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Decode for the current digit
    // -----------------------------------------------------------------------
    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lead_zero;   // digit k and every digit above it are zero
    logic                  zero_above;

    // NOTE: each always_comb assigns a default first, so no path can leave a
    // variable unassigned and infer a latch.
    always_comb begin
        zero_above = 1'b1;
        lead_zero  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib[k] = active[4*k +: 4];
        end
        // Scan from the most significant digit down. Digit 0 always shows.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above   = zero_above && (nib[k] == 4'h0);
            lead_zero[k] = zero_above && (k != 0);
        end
    end

    logic [6:0]            seg_on;
    logic                  dp_on;
    logic [NUM_DIGITS-1:0] en_on;
    logic                  cur_blank;
    logic                  cur_sup;

    always_comb begin
        cur_blank  = blank_i[idx];
        cur_sup    = lzs_i && lead_zero[idx];
        seg_on     = (cur_blank || cur_sup) ? 7'b0000000 : glyph(nib[idx]);
        // Suppression clears only the segments. The dp stays under user control.
        dp_on      = dp_i[idx] && !cur_blank;
        en_on      = '0;
        en_on[idx] = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 7; i++) begin
                display_o[i] <= POL_INV;
            end
            dp_o       <= POL_INV;
            digit_en_o <= {NUM_DIGITS{POL_INV}};
            frame_o    <= 1'b0;
        end else begin
            // Copy bit by bit so that display_o[i] takes seg_on[i] even
            // though the two ranges run in opposite directions.
            for (int i = 0; i < 7; i++) begin
                display_o[i] <= seg_on[i] ^ POL_INV;
            end
            dp_o       <= dp_on ^ POL_INV;
            digit_en_o <= en_on ^ {NUM_DIGITS{POL_INV}};
            // wrap_q is high exactly while idx is 0 for the first cycle of a
            // frame, so this pulse lines up with digit 0 on the outputs.
            frame_o    <= wrap_q;
        end
    end

endmodule
